// File: rtl/seq_lock_pkg.sv
// seq_lock_pkg: FSM state encoding, status-display constants and a max helper for seq_lock
package seq_lock_pkg;
  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_PROGRAM, S_LOCKOUT} state_t;
  localparam logic [3:0] HEX_OPEN = 4'hA;
  localparam logic [3:0] HEX_PROG = 4'hC;
  localparam logic [3:0] HEX_LOCK = 4'hF;
  function automatic int max_i(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/seq_lock_btn_edge.sv
// btn_edge: registers a debounced level (i_lvl) and pulses o_press for the cycle it first reads high; clk, async rst
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_lvl,
  output logic o_press
);
  logic r_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= 1'b0;
    else r_q <= i_lvl;
  assign o_press = i_lvl & ~r_q;
endmodule

// File: rtl/seq_lock.sv
// seq_lock: two-button code lock with lockout, timed open and reprogramming; in clk/reset_in/b0_in/b1_in/prog_en_in, out out/hex_display/fail_cnt/locked_out
module seq_lock
  import seq_lock_pkg::*;
#(
  parameter int                  CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0] CODE_INIT      = 4'b0110,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  LOCKOUT_CYCLES = 16,
  parameter int                  OPEN_CYCLES    = 8
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       b0_in,
  input  logic       b1_in,
  input  logic       prog_en_in,
  output logic       out,
  output logic [3:0] hex_display,
  output logic [3:0] fail_cnt,
  output logic       locked_out
);
  localparam int TW = max_i(1, $clog2(max_i(OPEN_CYCLES, LOCKOUT_CYCLES)));
  localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0] LEN4 = 4'(CODE_LEN);
  localparam logic [3:0] MAXF = 4'(MAX_FAIL);
  state_t r_state, w_state_nxt;
  logic [3:0] r_prog, w_prog_nxt, r_fail, w_fail_nxt, r_hex, w_hex_nxt;
  logic [CODE_LEN-1:0] r_code, w_code_nxt, r_new, w_new_nxt, w_shift;
  logic [TW-1:0] r_tmr, w_tmr_nxt;
  logic r_out, w_out_nxt, r_lock, w_lock_nxt;
  logic w_p0, w_p1, w_any, w_dig, w_exp;
  btn_edge u_b0 (.clk(clk), .rst(reset_in), .i_lvl(b0_in), .o_press(w_p0));
  btn_edge u_b1 (.clk(clk), .rst(reset_in), .i_lvl(b1_in), .o_press(w_p1));
  assign w_any   = w_p0 ^ w_p1;
  assign w_dig   = w_p1;
  assign w_shift = r_code << r_prog;
  assign w_exp   = w_shift[CODE_LEN-1];
  always_ff @(posedge clk or posedge reset_in)
    if (reset_in) begin
      r_state <= S_IDLE;
      r_prog  <= '0;
      r_code  <= CODE_INIT;
      r_new   <= '0;
      r_fail  <= '0;
      r_tmr   <= '0;
      r_out   <= 1'b0;
      r_hex   <= '0;
      r_lock  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prog  <= w_prog_nxt;
      r_code  <= w_code_nxt;
      r_new   <= w_new_nxt;
      r_fail  <= w_fail_nxt;
      r_tmr   <= w_tmr_nxt;
      r_out   <= w_out_nxt;
      r_hex   <= w_hex_nxt;
      r_lock  <= w_lock_nxt;
    end
  always_comb begin
    w_state_nxt = r_state;
    w_prog_nxt  = r_prog;
    w_code_nxt  = r_code;
    w_new_nxt   = r_new;
    w_fail_nxt  = r_fail;
    w_tmr_nxt   = r_tmr;
    case (r_state)
      S_IDLE:
        if (w_any) begin
          if (w_dig == w_exp) begin
            w_prog_nxt = r_prog + 4'd1;
            if (w_prog_nxt == LEN4) begin
              w_state_nxt = S_OPEN;
              w_prog_nxt  = '0;
              w_fail_nxt  = '0;
              w_tmr_nxt   = T_OPEN;
            end
          end else begin
            w_fail_nxt = r_fail + 4'd1;
            // a wrong digit that matches the first code digit already starts a new attempt
            w_prog_nxt = {3'b000, w_dig == r_code[CODE_LEN-1]};
            if (w_fail_nxt >= MAXF) begin
              w_state_nxt = S_LOCKOUT;
              w_prog_nxt  = '0;
              w_tmr_nxt   = T_LOCK;
            end
          end
        end
      S_OPEN:
        if (prog_en_in) begin
          w_state_nxt = S_PROGRAM;
          w_prog_nxt  = '0;
          w_new_nxt   = '0;
        end else if (r_tmr == '0) w_state_nxt = S_IDLE;
        else w_tmr_nxt = r_tmr - 1'b1;
      S_PROGRAM:
        if (w_any) begin
          w_new_nxt  = (r_new << 1) | CODE_LEN'(w_dig);
          w_prog_nxt = r_prog + 4'd1;
          if (w_prog_nxt == LEN4) begin
            w_code_nxt  = w_new_nxt;
            w_prog_nxt  = '0;
            w_state_nxt = S_IDLE;
          end
        end
      S_LOCKOUT:
        if (r_tmr == '0) begin
          w_state_nxt = S_IDLE;
          w_fail_nxt  = '0;
          w_prog_nxt  = '0;
        end else w_tmr_nxt = r_tmr - 1'b1;
      default: begin
        w_state_nxt = S_IDLE;
        w_prog_nxt  = '0;
      end
    endcase
  end
  always_comb begin
    w_out_nxt  = w_state_nxt == S_OPEN;
    w_lock_nxt = w_state_nxt == S_LOCKOUT;
    w_hex_nxt  = w_state_nxt == S_OPEN    ? HEX_OPEN :
                 w_state_nxt == S_PROGRAM ? HEX_PROG :
                 w_state_nxt == S_LOCKOUT ? HEX_LOCK : w_prog_nxt;
  end
  assign out         = r_out;
  assign hex_display = r_hex;
  assign fail_cnt    = r_fail;
  assign locked_out  = r_lock;
endmodule

// File: tb/tb_seq_lock.sv
// tb_seq_lock: directed self-checking bench for seq_lock with default parameters
module tb_seq_lock;
  logic clk = 1'b0, reset_in = 1'b1, b0_in = 1'b0, b1_in = 1'b0, prog_en_in = 1'b0;
  logic out, locked_out;
  logic [3:0] hex_display, fail_cnt;
  int n_cmp = 0, n_err = 0;
  seq_lock dut (
    .clk(clk), .reset_in(reset_in), .b0_in(b0_in), .b1_in(b1_in), .prog_en_in(prog_en_in),
    .out(out), .hex_display(hex_display), .fail_cnt(fail_cnt), .locked_out(locked_out)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input logic d);
    if (d) b1_in = 1'b1;
    else b0_in = 1'b1;
    @(negedge clk);
    b0_in = 1'b0;
    b1_in = 1'b0;
  endtask
  task automatic chk(input string tag, input logic e_out, input logic [3:0] e_hex,
                     input logic [3:0] e_fail, input logic e_lock);
    n_cmp++;
    assert (out === e_out) else begin
      n_err++;
      $error("FAIL %s.out observed=%b expected=%b", tag, out, e_out);
    end
    n_cmp++;
    assert (hex_display === e_hex) else begin
      n_err++;
      $error("FAIL %s.hex observed=%h expected=%h", tag, hex_display, e_hex);
    end
    n_cmp++;
    assert (fail_cnt === e_fail) else begin
      n_err++;
      $error("FAIL %s.fail_cnt observed=%0d expected=%0d", tag, fail_cnt, e_fail);
    end
    n_cmp++;
    assert (locked_out === e_lock) else begin
      n_err++;
      $error("FAIL %s.locked observed=%b expected=%b", tag, locked_out, e_lock);
    end
  endtask
  initial begin
    tick(1);
    chk("reset", 1'b0, 4'h0, 4'd0, 1'b0);
    tick(1);
    reset_in = 1'b0;
    tick(2);
    press(1'b0); chk("t1_d0", 1'b0, 4'h1, 4'd0, 1'b0); tick(3);
    press(1'b1); chk("t1_d1", 1'b0, 4'h2, 4'd0, 1'b0); tick(3);
    press(1'b1); chk("t1_d2", 1'b0, 4'h3, 4'd0, 1'b0); tick(3);
    press(1'b0); chk("t1_open", 1'b1, 4'hA, 4'd0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tick(1);
      chk($sformatf("t1_open%0d", i), 1'b1, 4'hA, 4'd0, 1'b0);
    end
    tick(1); chk("t1_close", 1'b0, 4'h0, 4'd0, 1'b0);
    tick(3);
    press(1'b1); chk("t2_f1", 1'b0, 4'h0, 4'd1, 1'b0); tick(3);
    press(1'b1); chk("t2_f2", 1'b0, 4'h0, 4'd2, 1'b0); tick(3);
    press(1'b1); chk("t2_lock", 1'b0, 4'hF, 4'd3, 1'b1); tick(3);
    press(1'b0); chk("t2_ign0", 1'b0, 4'hF, 4'd3, 1'b1); tick(3);
    press(1'b1); chk("t2_ign1", 1'b0, 4'hF, 4'd3, 1'b1); tick(7);
    chk("t2_last", 1'b0, 4'hF, 4'd3, 1'b1);
    tick(1); chk("t2_exit", 1'b0, 4'h0, 4'd0, 1'b0);
    tick(3);
    press(1'b0); chk("t3_d0", 1'b0, 4'h1, 4'd0, 1'b0); tick(3);
    press(1'b1); chk("t3_d1", 1'b0, 4'h2, 4'd0, 1'b0); tick(3);
    press(1'b0); chk("t3_wrong", 1'b0, 4'h1, 4'd1, 1'b0); tick(3);
    press(1'b1); chk("t3_r1", 1'b0, 4'h2, 4'd1, 1'b0); tick(3);
    press(1'b1); chk("t3_r2", 1'b0, 4'h3, 4'd1, 1'b0); tick(3);
    press(1'b0); chk("t3_open", 1'b1, 4'hA, 4'd0, 1'b0);
    prog_en_in = 1'b1;
    tick(1);
    prog_en_in = 1'b0;
    chk("t4_prog", 1'b0, 4'hC, 4'd0, 1'b0); tick(2);
    press(1'b1); chk("t4_p1", 1'b0, 4'hC, 4'd0, 1'b0); tick(3);
    press(1'b0); chk("t4_p2", 1'b0, 4'hC, 4'd0, 1'b0); tick(3);
    press(1'b0); chk("t4_p3", 1'b0, 4'hC, 4'd0, 1'b0); tick(3);
    press(1'b1); chk("t4_done", 1'b0, 4'h0, 4'd0, 1'b0); tick(3);
    press(1'b0); chk("t4_old0", 1'b0, 4'h0, 4'd1, 1'b0); tick(3);
    press(1'b1); chk("t4_old1", 1'b0, 4'h1, 4'd1, 1'b0); tick(3);
    press(1'b1); chk("t4_old2", 1'b0, 4'h1, 4'd2, 1'b0); tick(3);
    press(1'b0); chk("t4_old3", 1'b0, 4'h2, 4'd2, 1'b0); tick(3);
    press(1'b0); chk("t4_fin0", 1'b0, 4'h3, 4'd2, 1'b0); tick(3);
    press(1'b1); chk("t4_fin1", 1'b1, 4'hA, 4'd0, 1'b0); tick(8);
    chk("t4_close1", 1'b0, 4'h0, 4'd0, 1'b0); tick(3);
    press(1'b1); chk("t4_n1", 1'b0, 4'h1, 4'd0, 1'b0); tick(3);
    press(1'b0); chk("t4_n2", 1'b0, 4'h2, 4'd0, 1'b0); tick(3);
    press(1'b0); chk("t4_n3", 1'b0, 4'h3, 4'd0, 1'b0); tick(3);
    press(1'b1); chk("t4_new_open", 1'b1, 4'hA, 4'd0, 1'b0); tick(8);
    chk("t4_close2", 1'b0, 4'h0, 4'd0, 1'b0); tick(3);
    b0_in = 1'b1;
    b1_in = 1'b1;
    tick(1); chk("t5_both", 1'b0, 4'h0, 4'd0, 1'b0);
    b0_in = 1'b0;
    b1_in = 1'b0;
    tick(3);
    b1_in = 1'b1;
    tick(1); chk("t5_held1", 1'b0, 4'h1, 4'd0, 1'b0);
    tick(9); chk("t5_held10", 1'b0, 4'h1, 4'd0, 1'b0);
    b1_in = 1'b0;
    tick(3);
    press(1'b0); chk("t6_d1", 1'b0, 4'h2, 4'd0, 1'b0); tick(3);
    press(1'b0); chk("t6_d2", 1'b0, 4'h3, 4'd0, 1'b0); tick(3);
    press(1'b1); chk("t6_open", 1'b1, 4'hA, 4'd0, 1'b0);
    prog_en_in = 1'b1;
    tick(1);
    prog_en_in = 1'b0;
    chk("t6_prog", 1'b0, 4'hC, 4'd0, 1'b0); tick(2);
    press(1'b1); chk("t6_p1", 1'b0, 4'hC, 4'd0, 1'b0); tick(3);
    press(1'b0); chk("t6_p2", 1'b0, 4'hC, 4'd0, 1'b0);
    #2 reset_in = 1'b1;
    #1 chk("t6_async", 1'b0, 4'h0, 4'd0, 1'b0);
    @(negedge clk);
    reset_in = 1'b0;
    tick(2);
    press(1'b0); chk("t6_r0", 1'b0, 4'h1, 4'd0, 1'b0); tick(3);
    press(1'b1); chk("t6_r1", 1'b0, 4'h2, 4'd0, 1'b0); tick(3);
    press(1'b1); chk("t6_r2", 1'b0, 4'h3, 4'd0, 1'b0); tick(3);
    press(1'b0); chk("t6_reopen", 1'b1, 4'hA, 4'd0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_lock.md
Name: seq_lock

Overview:
- Parametrised successor to the two-button combination lock FSM.
- Accepts a binary code entered on two push-buttons (b0 = digit 0, b1 = digit 1) and has a configurable code length.
- The code is held in a register that can be reprogrammed while the lock is open.
- Adds failed-attempt counting with timed lockout, a timed unlock window and a status value for the hex display.
- Sits between the board button inputs and the LED/7-segment driver.

Parameters:
CODE_LEN, 4, number of digits in the code; legal range 1..14.
CODE_INIT, 4'b0110, reset code, CODE_LEN bits wide; bit CODE_LEN-1 is entered first.
MAX_FAIL, 3, consecutive wrong digits that trigger lockout; legal range 1..15.
LOCKOUT_CYCLES, 16, clock cycles spent in LOCKOUT; must be >= 1.
OPEN_CYCLES, 8, clock cycles `out` stays high after a correct code; must be >= 1.

Ports:
clk  in  1  system clock; all state changes on rising edge.
reset_in  in  1  asynchronous, active-high reset.
b0_in  in  1  button for digit 0, level input, already debounced.
b1_in  in  1  button for digit 1, level input, already debounced.
prog_en_in  in  1  request reprogramming; only honoured in OPEN.
out  out  1  unlock indication; high only in OPEN.
hex_display  out  4  status code for the 7-segment decoder.
fail_cnt  out  4  consecutive wrong-digit count.
locked_out  out  1  high while in LOCKOUT.

Behaviour:
- Reset (asynchronous, active-high):
  - Forces state=IDLE, progress=0, code_reg=CODE_INIT, fail_cnt=0, timer=0.
  - Clears the button history registers b0_q and b1_q to 0.
  - Output values during reset: out=0, hex_display=0, locked_out=0.
  - Reset asserted mid-entry, mid-OPEN or mid-PROGRAM abandons the operation. Any partially entered new code is discarded.
- Press detection:
  - A press event on bN is bN_in=1 at a clock edge while bN_q=0; bN_q holds bN_in from the previous edge.
  - One event per rising level; holding a button produces no repeats.
  - Simultaneous b0 and b1 events on the same edge are ignored: no state or counter change.
- All outputs are registered. A press acts on the edge where it is detected, and the updated outputs are valid after that edge (latency 1 clock from the first sampled-high edge).
- State IDLE/ENTER (single state, tracked by progress 0..CODE_LEN-1):
  - Expected digit = code_reg[CODE_LEN-1-progress].
  - Correct digit:
    - progress+1; fail_cnt unchanged.
    - If progress reaches CODE_LEN: go to OPEN, progress=0, fail_cnt=0, timer=OPEN_CYCLES-1.
  - Wrong digit:
    - fail_cnt+1.
    - progress becomes 1 if the wrong digit equals code_reg[CODE_LEN-1], else 0.
    - If fail_cnt+1 == MAX_FAIL: go to LOCKOUT, progress=0, timer=LOCKOUT_CYCLES-1.
- State OPEN:
  - out=1.
  - Timer decrements every cycle. At 0 the FSM returns to IDLE on the next edge, giving exactly OPEN_CYCLES cycles of out=1.
  - prog_en_in=1 at any OPEN edge: go to PROGRAM, clear shift register and progress, out=0 from that edge.
  - Button presses in OPEN are ignored.
- State PROGRAM:
  - Each press shifts its digit into new_code (first press ends up in the MSB) and increments progress.
  - After CODE_LEN presses: code_reg<=new_code, progress=0, go to IDLE.
  - No timeout. fail_cnt is not affected.
- State LOCKOUT:
  - All presses are ignored; locked_out=1.
  - Timer decrements each cycle. At 0 go to IDLE with fail_cnt=0 and progress=0.
- hex_display:
  - IDLE/ENTER: progress (0..CODE_LEN-1).
  - OPEN: 4'hA. PROGRAM: 4'hC. LOCKOUT: 4'hF.
- Widths: timer is clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES)) bits; progress is 4 bits; fail_cnt saturates at MAX_FAIL.
- Illegal state encoding: recovers to IDLE on the next edge.

Decomposition:
- Package seq_lock_pkg holds:
  - the state enum (S_IDLE, S_OPEN, S_PROGRAM, S_LOCKOUT);
  - hex constants HEX_OPEN=4'hA, HEX_PROG=4'hC, HEX_LOCK=4'hF.
- One sub-module, btn_edge: registers a level input and emits a one-cycle press pulse. It is instantiated twice (b0, b1).
- The FSM, timer and code register stay in seq_lock.

Test Plan:
- Defaults; reset, then press 0,1,1,0 (one clk high, three low per press):
  - hex_display steps 0→1→2→3;
  - then out=1, hex_display=A for exactly 8 cycles;
  - then out=0, hex_display=0.
- Press 1,1,1 from IDLE → fail_cnt 1,2, then locked_out=1, hex_display=F for 16 cycles. Presses during that window change nothing. Afterwards fail_cnt=0, hex_display=0.
- Press 0,1,0 (wrong third digit), then 1,1,0 → unlock occurs:
  - the wrong 0 restarts progress at 1, fail_cnt=1;
  - fail_cnt clears to 0 on unlock.
- Unlock, assert prog_en_in in OPEN, enter 1,0,0,1:
  - hex_display=C during entry, then IDLE.
  - Old code 0110 now fails.
  - 1001 now unlocks.
- Drive b0_in and b1_in rising on the same edge, and hold b1_in high for 10 cycles → exactly one press is registered (the held b1), and no change on the simultaneous edge.
- Assert reset_in asynchronously mid-PROGRAM after two digits → outputs are 0 immediately; code 0110 unlocks afterwards.
